mat_serializer: RTL
===================

Name: mat_serializer

Overview:
- Consumer end of the packed-matrix stb/ack interface that mat_sum and the other linalg blocks drive.
- Accepts one M x N matrix of W-bit words (IEEE-754 single by default) in a single handshake.
- Replays the matrix as a stream of scalar elements in row-major order over a scalar stb/ack interface.
- Sits between a matrix-producing linalg block and scalar sinks: UART/debug dump, scalar FPU, BRAM writer.

Parameters:
- M, 2, matrix rows (>=1)
- N, 3, matrix columns (>=1)
- W, 32, element width in bits

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- input_mat  input  M*N*W  packed matrix. Element k (row-major, k = r*N+c, k=0 first) occupies bits [(M*N-1-k)*W +: W], so element (0,0) is the MSB word.
- input_mat_stb  input  1  producer has a valid matrix
- input_mat_ack  output  1  serializer can accept a matrix
- output_elem  output  W  current scalar element
- output_elem_stb  output  1  output_elem valid
- output_elem_ack  input  1  sink accepts output_elem

Behaviour:
- Transfer rule, both interfaces: a transfer occurs on a rising edge where stb and ack are both 1.
- Reset (rst=0, asynchronous, any time including mid-stream):
  - state=IDLE, idx=0, buffer cleared to 0
  - input_mat_ack=0 while rst=0
  - output_elem_stb=0, output_elem=0
  - A partially sent matrix is discarded; no element is re-sent after reset.
- IDLE state:
  - input_mat_ack=1, output_elem_stb=0.
  - On input transfer: latch input_mat into the internal buffer, idx<=0, go to SEND.
  - input_mat_ack is registered; it is 1 from the first edge after rst deasserts.
- SEND state:
  - input_mat_ack=0; output_elem_stb=1; output_elem=buffer element idx, driven from a register or mux of registers with no combinational path from inputs.
  - On output transfer with idx<M*N-1: idx<=idx+1; stb stays 1.
  - On output transfer with idx=M*N-1: go to IDLE, idx<=0.
  - Without ack: idx, output_elem and stb are held stable indefinitely.
- Latency:
  - First element valid on the edge after the input transfer (1 cycle).
  - With ack held high: one element per cycle, M*N cycles.
  - 1 IDLE cycle between matrices; throughput is one matrix per M*N+1 cycles.
- Boundary cases:
  - input_mat_stb while in SEND: ignored (ack=0); the matrix is not latched, and the producer must hold it.
  - input_mat changing while in SEND: no effect on the buffer.
  - M=N=1: SEND lasts exactly one transfer.
  - idx width is clog2(M*N), minimum 1 bit; idx never exceeds M*N-1.
  - output_elem_ack while stb=0: no effect.
- No arithmetic on data; elements are passed bit-exact.

Optional Feature:
- Macro: MAT_SERIALIZER_LAST_EN.
- Defined:
  - Adds output port output_elem_last (output, 1 bit).
  - output_elem_last = 1 exactly when output_elem_stb=1 and idx=M*N-1; otherwise 0; reset value 0.
- Undefined:
  - Port absent; behaviour otherwise identical.

Decomposition:
- Shared package linalg_pkg:
  - localparam FP_W=32, the default element width.
  - typedef enum logic {IDLE, SEND} mat_ser_state_t.
  - Function idx_w(n) returning max(1, clog2(n)).
- No sub-module; a single always_ff FSM/counter plus an element mux is sufficient.

Test Plan:
- Basic stream:
  - Stimulus: M=2,N=3; input_mat={3F800000,40000000,40400000,40800000,40A00000,40C00000} ([1,2,3;4,5,6]); stb=1, output ack=1.
  - Response: ack pulse in IDLE; next 6 cycles output_elem = 3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000; stb low for 1 cycle; then the same matrix accepted again.
- Backpressure:
  - Stimulus: output_elem_ack=0 for 4 cycles while idx=2.
  - Response: output_elem holds 40400000, stb=1, idx unchanged; resumes with 40800000 when ack returns.
- Busy input:
  - Stimulus: while in SEND, change input_mat to [3,4,5;6,1,2] with stb=1.
  - Response: input_mat_ack=0; current stream is unaltered. The new matrix is latched only in the next IDLE cycle, then streams 40400000, 40800000, 40A00000, 40C00000, 3F800000, 40000000.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously after the 3rd element transfer.
  - Response: output_elem_stb and input_mat_ack drop to 0 without waiting for a clock edge; after release, the next stream starts at element 0.
- Degenerate size:
  - Stimulus: M=1,N=1 instance; input 41300000.
  - Response: a single element 41300000, then IDLE; with MAT_SERIALIZER_LAST_EN, output_elem_last=1 on that element.
- LAST flag:
  - Stimulus: MAT_SERIALIZER_LAST_EN defined, default M,N.
  - Response: output_elem_last=1 only alongside the 6th element (40C00000 in scenario 1), 0 elsewhere and during reset.

Source files
------------

// File: rtl/linalg_pkg.sv
// rtl/linalg_pkg.sv - shared linalg types, default element width and index-width helper
package linalg_pkg;

  localparam int FP_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } mat_ser_state_t;

  // Index width for a count of n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mat_serializer.sv
// rtl/mat_serializer.sv - packed M x N matrix to row-major scalar stream; optional MAT_SERIALIZER_LAST_EN adds output_elem_last
module mat_serializer
  import linalg_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 3,
  parameter int W = FP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M*N*W-1:0] input_mat,
  input  logic             input_mat_stb,
  output logic             input_mat_ack,
  output logic [W-1:0]     output_elem,
  output logic             output_elem_stb,
`ifdef MAT_SERIALIZER_LAST_EN
  output logic             output_elem_last,
`endif
  input  logic             output_elem_ack
);

  localparam int TOTAL = M * N;
  localparam int IDX_W = idx_w(TOTAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  mat_ser_state_t   r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_ack;
  logic [W-1:0]     r_buf [TOTAL];

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [W-1:0]     w_elem;

  assign w_in_xfer  = r_ack & input_mat_stb;
  assign w_out_xfer = (r_state == SEND) & output_elem_ack;

  // FSM, element index and matrix buffer; buffer only loads on an accepted matrix
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ack   <= 1'b0;
      for (int k = 0; k < TOTAL; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b1;
          if (w_in_xfer) begin
            for (int k = 0; k < TOTAL; k++) begin
              r_buf[k] <= input_mat[(TOTAL-1-k)*W +: W];
            end
            r_idx   <= '0;
            r_state <= SEND;
            r_ack   <= 1'b0;
          end
        end
        SEND: begin
          if (w_out_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= IDLE;
              r_ack   <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Element select from registered buffer and index only
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < TOTAL; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_elem = r_buf[k];
      end
    end
  end

  assign input_mat_ack   = r_ack;
  assign output_elem     = w_elem;
  assign output_elem_stb = (r_state == SEND);
`ifdef MAT_SERIALIZER_LAST_EN
  assign output_elem_last = (r_state == SEND) && (r_idx == LAST_IDX);
`endif

endmodule
